// File: rtl/cam_cfg_seq.sv
// cam_cfg_seq: OV5640 power-up and register-configuration sequencer.
// Waits out the sensor power-up delay, then walks an external registered ROM
// of {addr[15:0], data[7:0]} entries. Each entry becomes one SCCB write over
// a req/done handshake, with a bounded number of retries on NACK. cfg_done
// rises once the whole table is written and gates downstream pixel capture.
//
// Optional build macro: CAM_CFG_DELAY_EN
//   defined   -> table entries with addr 16'hFFFF are not sent to the SCCB
//                master. Their data byte becomes a wait in milliseconds
//                (DLY state), used for sensor settle time after soft reset.
//   undefined -> 16'hFFFF is an ordinary address. No DLY state or counter.

`timescale 1ns/1ps

module cam_cfg_seq #(
  parameter int CLK_MS    = 25000,  // clock cycles per millisecond
  parameter int PWR_MS    = 20,     // power-up wait before first write, ms
  parameter int REG_NUM   = 252,    // table entries, 1..255
  parameter int MAX_RETRY = 3       // NACKed attempts allowed per entry
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [7:0]  tbl_idx,
  input  logic [23:0] tbl_data,
  output logic        sccb_req,
  output logic [15:0] sccb_addr,
  output logic [7:0]  sccb_wdata,
  input  logic        sccb_busy,
  input  logic        sccb_done,
  input  logic        sccb_nack,
  output logic        cfg_busy,
  output logic        cfg_done,
  output logic        cfg_err
);

  // Counter widths; clamp to one bit so degenerate parameters still elaborate.
  localparam int MS_W = (CLK_MS > 1) ? $clog2(CLK_MS) : 1;
  localparam int PT_W = (PWR_MS > 1) ? $clog2(PWR_MS) : 1;
  localparam int RT_W = $clog2(MAX_RETRY + 1);

  typedef enum logic [3:0] {
    S_PWR,
    S_FETCH,
    S_LATCH,
    S_ISSUE,
    S_WAIT,
    S_NEXT,
`ifdef CAM_CFG_DELAY_EN
    S_DLY,
`endif
    S_DONE,
    S_ERR
  } state_t;

  state_t            state;
  state_t            state_nxt;

  logic [MS_W-1:0]   ms_cnt;     // cycles within the current millisecond
  logic [PT_W-1:0]   pwr_cnt;    // whole milliseconds of power-up elapsed
  logic [RT_W-1:0]   retry_cnt;  // NACKed attempts on the current entry

  logic              ms_wrap;
  logic              pwr_last;
  logic              retry_last;
  logic              idx_last;

`ifdef CAM_CFG_DELAY_EN
  logic [7:0]        dly_cnt;    // whole milliseconds of DLY elapsed
  logic              dly_entry;
  logic              dly_last;
`endif

  // Terminal-count decodes shared by the FSM and the datapath.
  assign ms_wrap    = (ms_cnt == MS_W'(CLK_MS - 1));
  assign pwr_last   = ms_wrap && (pwr_cnt == PT_W'(PWR_MS - 1));
  assign retry_last = (int'(retry_cnt) + 1) >= MAX_RETRY;
  assign idx_last   = (tbl_idx == 8'(REG_NUM - 1));

`ifdef CAM_CFG_DELAY_EN
  // A delay pseudo-entry is recognised on the ROM word, during LATCH.
  assign dly_entry  = (tbl_data[23:8] == 16'hFFFF);
  // Data 0 means a single cycle in DLY; N means N full milliseconds.
  assign dly_last   = (sccb_wdata == 8'd0) ||
                      (ms_wrap && (dly_cnt == sccb_wdata - 8'd1));
`endif

  // Status outputs decode straight from the state so they track it exactly.
  assign cfg_busy = (state != S_DONE) && (state != S_ERR);
  assign cfg_done = (state == S_DONE);
  assign cfg_err  = (state == S_ERR);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_PWR;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode.
  always_comb begin
    // NOTE: default assigned before the case so no path leaves state_nxt
    // unassigned, which would otherwise infer a latch.
    state_nxt = state;
    case (state)
      S_PWR: begin
        if (pwr_last) state_nxt = S_FETCH;
      end
      S_FETCH: begin
        // tbl_idx was set on entry; the ROM word appears next cycle.
        state_nxt = S_LATCH;
      end
      S_LATCH: begin
`ifdef CAM_CFG_DELAY_EN
        state_nxt = dly_entry ? S_DLY : S_ISSUE;
`else
        state_nxt = S_ISSUE;
`endif
      end
      S_ISSUE: begin
        if (!sccb_busy) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        // nack is only meaningful alongside done.
        if (sccb_done) begin
          if (!sccb_nack)     state_nxt = S_NEXT;
          else if (retry_last) state_nxt = S_ERR;
          else                 state_nxt = S_ISSUE;
        end
      end
      S_NEXT: begin
        state_nxt = idx_last ? S_DONE : S_FETCH;
      end
`ifdef CAM_CFG_DELAY_EN
      S_DLY: begin
        if (dly_last) state_nxt = S_NEXT;
      end
`endif
      S_DONE, S_ERR: begin
        // Restart skips the power-up wait: the sensor is already powered.
        if (start) state_nxt = S_FETCH;
      end
      default: state_nxt = S_PWR;
    endcase
  end

  // Datapath: table index, SCCB request/payload and the wait counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      tbl_idx    <= '0;
      sccb_req   <= 1'b0;
      sccb_addr  <= '0;
      sccb_wdata <= '0;
      ms_cnt     <= '0;
      pwr_cnt    <= '0;
      retry_cnt  <= '0;
`ifdef CAM_CFG_DELAY_EN
      dly_cnt    <= '0;
`endif
    end else begin
      // NOTE: non-blocking throughout, so every decode above sees the
      // pre-edge values regardless of statement order.
      // Registered request: one pulse, in the first WAIT cycle.
      sccb_req <= (state == S_ISSUE) && !sccb_busy;

      case (state)
        S_PWR: begin
          ms_cnt <= ms_wrap ? '0 : ms_cnt + 1'b1;
          if (ms_wrap) pwr_cnt <= pwr_last ? '0 : pwr_cnt + 1'b1;
        end
        S_LATCH: begin
          // Payload stays put until the next LATCH, covering req..done.
          sccb_addr  <= tbl_data[23:8];
          sccb_wdata <= tbl_data[7:0];
          retry_cnt  <= '0;
          ms_cnt     <= '0;
`ifdef CAM_CFG_DELAY_EN
          dly_cnt    <= '0;
`endif
        end
        S_WAIT: begin
          if (sccb_done && sccb_nack && !retry_last) begin
            retry_cnt <= retry_cnt + 1'b1;
          end
        end
        S_NEXT: begin
          // Saturate at the last entry; DONE is taken instead of wrapping.
          if (!idx_last) tbl_idx <= tbl_idx + 8'd1;
        end
`ifdef CAM_CFG_DELAY_EN
        S_DLY: begin
          ms_cnt <= ms_wrap ? '0 : ms_cnt + 1'b1;
          if (ms_wrap) dly_cnt <= dly_cnt + 8'd1;
        end
`endif
        S_DONE, S_ERR: begin
          // In ERR tbl_idx is left on the failing entry until restart.
          if (start) tbl_idx <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cam_cfg_seq.sv
// tb_cam_cfg_seq: directed self-checking bench for cam_cfg_seq.
// CLK_MS=10, PWR_MS=2 (20-cycle power-up), REG_NUM=4, MAX_RETRY=3.
// Cycle k is the k-th clock interval after the last posedge with rst high.
// Idle timing: FETCH 20, LATCH 21, ISSUE 22, req 23, done 26, next req 31.

`timescale 1ns/1ps

module tb_cam_cfg_seq;

  localparam int CLK_MS    = 10;
  localparam int PWR_MS    = 2;
  localparam int REG_NUM   = 4;
  localparam int MAX_RETRY = 3;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  tbl_idx;
  logic [23:0] tbl_data;
  logic        sccb_req;
  logic [15:0] sccb_addr;
  logic [7:0]  sccb_wdata;
  logic        sccb_busy;
  logic        sccb_done;
  logic        sccb_nack;
  logic        cfg_busy;
  logic        cfg_done;
  logic        cfg_err;

  cam_cfg_seq #(
    .CLK_MS    (CLK_MS),
    .PWR_MS    (PWR_MS),
    .REG_NUM   (REG_NUM),
    .MAX_RETRY (MAX_RETRY)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .tbl_idx    (tbl_idx),
    .tbl_data   (tbl_data),
    .sccb_req   (sccb_req),
    .sccb_addr  (sccb_addr),
    .sccb_wdata (sccb_wdata),
    .sccb_busy  (sccb_busy),
    .sccb_done  (sccb_done),
    .sccb_nack  (sccb_nack),
    .cfg_busy   (cfg_busy),
    .cfg_done   (cfg_done),
    .cfg_err    (cfg_err)
  );

  typedef struct {
    int          idx;
    logic [15:0] addr;
    logic [7:0]  data;
    int          cyc;
  } req_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc;
  logic [23:0] rom [4];
  req_t        log_q[$];

  // SCCB model controls
  int nack_idx;        // entry that gets NACKed
  int nack_n;          // number of NACKs given on that entry
  int busy_after_idx;  // after done of this entry, busy for 10 cycles
  int busy_from;
  int busy_until;
  int att [4];
  int stab_err;
  int busy_req_err;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Cycle counter, zero in the first cycle after reset release.
  always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

  // Registered ROM: data valid one cycle after tbl_idx.
  always @(posedge clk) tbl_data <= (tbl_idx < 8'd4) ? rom[tbl_idx[1:0]] : 24'h0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // SCCB slave model, evaluated on the falling edge.
  initial begin : sccb_model
    logic        pend;
    int          done_at;
    int          cur_idx;
    logic        cur_nack;
    logic        prev_busy;
    logic [15:0] p_addr;
    logic [7:0]  p_data;
    pend = 1'b0; done_at = 0; cur_idx = 0; cur_nack = 1'b0; prev_busy = 1'b0;
    p_addr = '0; p_data = '0;
    sccb_busy = 1'b0; sccb_done = 1'b0; sccb_nack = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pend = 1'b0; sccb_busy = 1'b0; sccb_done = 1'b0; sccb_nack = 1'b0;
        prev_busy = 1'b0;
      end else begin
        sccb_done = 1'b0;
        sccb_nack = 1'b1;  // stray nack without done must be ignored
        if (sccb_req) begin
          if (prev_busy) busy_req_err++;
          log_q.push_back('{idx: int'(tbl_idx), addr: sccb_addr, data: sccb_wdata, cyc: cyc});
          pend     = 1'b1;
          done_at  = cyc + 3;
          cur_idx  = int'(tbl_idx);
          p_addr   = sccb_addr;
          p_data   = sccb_wdata;
          if (cur_idx < 4) att[cur_idx]++;
          cur_nack = (cur_idx == nack_idx) && (att[cur_idx] <= nack_n);
        end else if (pend) begin
          if (sccb_addr != p_addr || sccb_wdata != p_data) stab_err++;
          if (cyc == done_at) begin
            sccb_done = 1'b1;
            sccb_nack = cur_nack;
            pend      = 1'b0;
            if (cur_idx == busy_after_idx) begin
              busy_from  = cyc + 1;
              busy_until = cyc + 10;
            end
          end
        end
        sccb_busy = (cyc >= busy_from) && (cyc <= busy_until);
        prev_busy = sccb_busy;
      end
    end
  end

  // Assert rst, check the reset state, clear the model, release in cycle 0.
  task automatic do_reset(input string tag);
    rst   = 1'b1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check({tag, "_rst_outs"},
          {28'd0, tbl_idx, sccb_req, sccb_addr, sccb_wdata, cfg_done, cfg_err, cfg_busy},
          {28'd0, 8'd0, 1'b0, 16'd0, 8'd0, 1'b0, 1'b0, 1'b1});
    log_q.delete();
    for (int i = 0; i < 4; i++) att[i] = 0;
    nack_idx = -1; nack_n = 0; busy_after_idx = -1;
    busy_from = 1000000; busy_until = 0;
    stab_err = 0; busy_req_err = 0;
    rst = 1'b0;
  endtask

  // Run until cfg_done or cfg_err; report the first cycle seen and busy before it.
  task automatic run_until_end(input string tag, output int end_cyc, output logic busy_before);
    end_cyc = -1;
    busy_before = 1'b0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (cfg_done || cfg_err) begin
        end_cyc = cyc;
        return;
      end
      busy_before = cfg_busy;
    end
    check({tag, "_timeout"}, 64'd1, 64'd0);
  endtask

  task automatic check_entry(input string tag, input int k, input int idx, input int exp_cyc);
    if (k >= log_q.size()) begin
      check({tag, "_missing"}, 64'(k), 64'(log_q.size()));
      return;
    end
    check({tag, "_idx"},  64'(log_q[k].idx), 64'(idx));
    check({tag, "_addr"}, 64'(log_q[k].addr), 64'(rom[idx][23:8]));
    check({tag, "_data"}, 64'(log_q[k].data), 64'(rom[idx][7:0]));
    check({tag, "_cyc"},  64'(log_q[k].cyc), 64'(exp_cyc));
  endtask

  task automatic load_rom();
    rom[0] = 24'h3103_11;
    rom[1] = 24'h3008_82;
    rom[2] = 24'h3008_42;
    rom[3] = 24'h3103_03;
  endtask

  initial begin : main
    int   end_cyc;
    logic busy_before;
    rst = 1'b1; start = 1'b0;
    load_rom();

    // 1: ideal SCCB, 4 writes, cfg_done two cycles after last done (NEXT between).
    do_reset("t1");
    run_until_end("t1", end_cyc, busy_before);
    check("t1_nreq", 64'(log_q.size()), 64'd4);
    for (int i = 0; i < 4; i++) check_entry($sformatf("t1_e%0d", i), i, i, 23 + 8 * i);
    check("t1_done_cyc", 64'(end_cyc), 64'd52);
    check("t1_flags", {61'd0, cfg_done, cfg_err, cfg_busy}, {61'd0, 1'b1, 1'b0, 1'b0});
    check("t1_busy_before", 64'(busy_before), 64'd1);
    check("t1_stable", 64'(stab_err), 64'd0);

    // 2: master busy for 10 cycles after entry 1 done (7 of them in ISSUE).
    do_reset("t2");
    busy_after_idx = 1;
    run_until_end("t2", end_cyc, busy_before);
    check("t2_nreq", 64'(log_q.size()), 64'd4);
    check_entry("t2_e1", 1, 1, 31);
    check_entry("t2_e2", 2, 2, 46);
    check_entry("t2_e3", 3, 3, 54);
    check("t2_req_when_busy", 64'(busy_req_err), 64'd0);
    check("t2_stable", 64'(stab_err), 64'd0);
    check("t2_done_cyc", 64'(end_cyc), 64'd59);

    // 3: entry 2 NACKed twice then ACKed.
    do_reset("t3");
    nack_idx = 2; nack_n = 2;
    run_until_end("t3", end_cyc, busy_before);
    check("t3_nreq", 64'(log_q.size()), 64'd6);
    check_entry("t3_try0", 2, 2, 39);
    check_entry("t3_try1", 3, 2, 44);
    check_entry("t3_try2", 4, 2, 49);
    check_entry("t3_e3", 5, 3, 57);
    check("t3_done_cyc", 64'(end_cyc), 64'd62);
    check("t3_flags", {62'd0, cfg_done, cfg_err}, {62'd0, 1'b1, 1'b0});

    // 4: entry 1 always NACKed -> ERR after 3 attempts, then restart.
    do_reset("t4");
    nack_idx = 1; nack_n = 255;
    run_until_end("t4", end_cyc, busy_before);
    check("t4_nreq", 64'(log_q.size()), 64'd4);
    check_entry("t4_try2", 3, 1, 41);
    check("t4_err_cyc", 64'(end_cyc), 64'd45);
    repeat (3) @(negedge clk);  // cycle 48, still in ERR
    check("t4_err_state", {52'd0, tbl_idx, cfg_done, cfg_err, cfg_busy},
          {52'd0, 8'd1, 1'b0, 1'b1, 1'b0});
    nack_n = 0;
    start = 1'b1;
    @(negedge clk);              // cycle 49, FETCH
    start = 1'b0;
    check("t4_restart", {54'd0, tbl_idx, cfg_err, cfg_busy}, {54'd0, 8'd0, 1'b0, 1'b1});
    repeat (4) @(negedge clk);   // cycle 53, one past the restart req
    check_entry("t4_re0", 4, 0, 52);
    run_until_end("t4b", end_cyc, busy_before);
    check("t4_re_flags", {62'd0, cfg_done, cfg_err}, {62'd0, 1'b1, 1'b0});

    // 5: start in WAIT is ignored; rst during entry 3 reruns the power-up wait.
    do_reset("t5");
    repeat (23) @(negedge clk);  // cycle 23, WAIT of entry 0
    check("t5_req0", 64'(sccb_req), 64'd1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (24) @(negedge clk);  // cycle 48, WAIT of entry 3
    check("t5_idx3", 64'(tbl_idx), 64'd3);
    check("t5_nreq", 64'(log_q.size()), 64'd4);
    check_entry("t5_e1", 1, 1, 31);
    do_reset("t5_mid");
    repeat (30) @(negedge clk);  // cycle 30
    check("t5_nreq_after", 64'(log_q.size()), 64'd1);
    check_entry("t5_after_e0", 0, 0, 23);
    run_until_end("t5", end_cyc, busy_before);
    check("t5_done", 64'(cfg_done), 64'd1);

    // 6: entry 1 carries address FFFF, data 3.
    rom[1] = 24'hFFFF_03;
    do_reset("t6");
    run_until_end("t6", end_cyc, busy_before);
`ifdef CAM_CFG_DELAY_EN
    check("t6_nreq", 64'(log_q.size()), 64'd3);
    check_entry("t6_e2", 1, 2, 64);
    check("t6_done_cyc", 64'(end_cyc), 64'd77);
`else
    check("t6_nreq", 64'(log_q.size()), 64'd4);
    check_entry("t6_e1", 1, 1, 31);
    check("t6_done_cyc", 64'(end_cyc), 64'd52);
`endif
    check("t6_done", 64'(cfg_done), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
